// File: rtl/clock_pkg.sv
// Shared alarm-clock definitions: keypad codes, controller state encodings and output decode.
// Used by the controller, keypad scanner and key buffer so all agree on codes.
package clock_pkg;

  localparam int unsigned TIMEOUT_SEC = 10;

  localparam logic [3:0] KEY_ALARM = 4'hA;
  localparam logic [3:0] KEY_TIME  = 4'hB;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    SHOW_ALARM       = 3'd1,
    KEY_STORED       = 3'd2,
    KEY_WAITED       = 3'd3,
    KEY_ENTRY        = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } ctrl_state_t;

  typedef struct packed {
    logic show_new_time;
    logic show_a;
    logic shift;
    logic load_new_a;
    logic load_new_c;
  } ctrl_out_t;

  // Moore output table; unlisted encodings decode to all-quiet.
  function automatic ctrl_out_t decode_state(input ctrl_state_t s);
    ctrl_out_t o;
    o = '0;
    case (s)
      SHOW_ALARM: o.show_a = 1'b1;
      KEY_STORED: begin
        o.shift         = 1'b1;
        o.show_new_time = 1'b1;
      end
      KEY_WAITED,
      KEY_ENTRY: o.show_new_time = 1'b1;
      SET_ALARM_TIME: begin
        o.load_new_a    = 1'b1;
        o.show_new_time = 1'b1;
      end
      SET_CURRENT_TIME: begin
        o.load_new_c    = 1'b1;
        o.show_new_time = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Saturating seconds counter for entry inactivity; timeout is a level while at the limit.
// Count updates one clock after clr/en/one_second are sampled; no backpressure.
module ctrl_timeout_cnt #(
  parameter int unsigned TIMEOUT_SEC = clock_pkg::TIMEOUT_SEC
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic one_second,
  output logic timeout
);

  localparam logic [3:0] LIMIT = 4'(TIMEOUT_SEC);

  logic [3:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && one_second && (cnt < LIMIT)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock sequencer: decodes keypad codes into display selects and load/shift strobes.
// Strobes appear one clock after the key is sampled; no backpressure, every strobe is one cycle.
module alarm_clock_ctrl #(
  parameter int unsigned TIMEOUT_SEC = clock_pkg::TIMEOUT_SEC,
  parameter logic [3:0]  KEY_ALARM   = clock_pkg::KEY_ALARM,
  parameter logic [3:0]  KEY_TIME    = clock_pkg::KEY_TIME,
  parameter logic [3:0]  KEY_NONE    = clock_pkg::KEY_NONE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  output logic       show_new_time,
  output logic       show_a,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       timeout
);

  import clock_pkg::*;

  ctrl_state_t state;
  ctrl_state_t nxt;
  ctrl_out_t   outs;
  logic        tmo_clr;
  logic        tmo_en;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // Codes C..E are unassigned on the keypad and behave like a released key.
  function automatic logic is_none(input logic [3:0] k);
    return (k == KEY_NONE) || ((k >= 4'hC) && (k <= 4'hE));
  endfunction

  function automatic ctrl_state_t next_state(input ctrl_state_t s,
                                             input logic [3:0]  k,
                                             input logic        tmo);
    ctrl_state_t n;
    n = SHOW_TIME;
    case (s)
      SHOW_TIME: begin
        if (k == KEY_ALARM)  n = SHOW_ALARM;
        else if (is_digit(k)) n = KEY_STORED;
        else                  n = SHOW_TIME;
      end
      SHOW_ALARM: n = (k == KEY_ALARM) ? SHOW_ALARM : SHOW_TIME;
      KEY_STORED: n = KEY_WAITED;
      KEY_WAITED: begin
        if (is_none(k)) n = KEY_ENTRY;
        else if (tmo)   n = SHOW_TIME;
        else            n = KEY_WAITED;
      end
      // A real key beats a timeout arriving in the same cycle.
      KEY_ENTRY: begin
        if (is_digit(k))        n = KEY_STORED;
        else if (k == KEY_ALARM) n = SET_ALARM_TIME;
        else if (k == KEY_TIME)  n = SET_CURRENT_TIME;
        else if (tmo)            n = SHOW_TIME;
        else                     n = KEY_ENTRY;
      end
      SET_ALARM_TIME,
      SET_CURRENT_TIME: n = SHOW_TIME;
      default: n = SHOW_TIME;
    endcase
    return n;
  endfunction

  assign nxt = next_state(state, key, timeout);

  // Outputs are registered from the next-state decode so they track the state register exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SHOW_TIME;
      outs  <= '0;
    end else begin
      state <= nxt;
      outs  <= decode_state(nxt);
    end
  end

  assign tmo_clr = (state == SHOW_TIME) || (state == SHOW_ALARM) || (state == KEY_STORED);
  assign tmo_en  = (state == KEY_WAITED) || (state == KEY_ENTRY);

  ctrl_timeout_cnt #(
    .TIMEOUT_SEC(TIMEOUT_SEC)
  ) u_timeout_cnt (
    .clock      (clock),
    .reset      (reset),
    .clr        (tmo_clr),
    .en         (tmo_en),
    .one_second (one_second),
    .timeout    (timeout)
  );

  assign show_new_time = outs.show_new_time;
  assign show_a        = outs.show_a;
  assign shift         = outs.shift;
  assign load_new_a    = outs.load_new_a;
  assign load_new_c    = outs.load_new_c;

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Directed-vector bench for alarm_clock_ctrl with hand-computed expectations.
module tb_alarm_clock_ctrl;
  import clock_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'hF;
  logic       show_new_time, show_a, shift, load_new_a, load_new_c, timeout;
  logic [4:0] outv;

  int n_vec = 0;
  int n_err = 0;
  int n_shift, n_la, n_lc, n_sa, n_snt;

  alarm_clock_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .one_second    (one_second),
    .key           (key),
    .show_new_time (show_new_time),
    .show_a        (show_a),
    .shift         (shift),
    .load_new_a    (load_new_a),
    .load_new_c    (load_new_c),
    .timeout       (timeout)
  );

  always #5 clock = ~clock;

  // {show_new_time, show_a, shift, load_new_a, load_new_c}
  assign outv = {show_new_time, show_a, shift, load_new_a, load_new_c};

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    n_shift = 0; n_la = 0; n_lc = 0; n_sa = 0; n_snt = 0;
  endtask

  task automatic step(input logic [3:0] k, input logic os);
    key = k;
    one_second = os;
    @(posedge clock);
    #1;
    one_second = 1'b0;
    if (shift)         n_shift++;
    if (load_new_a)    n_la++;
    if (load_new_c)    n_lc++;
    if (show_a)        n_sa++;
    if (show_new_time) n_snt++;
  endtask

  logic [3:0] digs_a [4];
  logic [3:0] digs_c [4];

  initial begin
    digs_a[0] = 4'd1; digs_a[1] = 4'd2; digs_a[2] = 4'd3; digs_a[3] = 4'd0;
    digs_c[0] = 4'd0; digs_c[1] = 4'd7; digs_c[2] = 4'd4; digs_c[3] = 4'd5;
    clr_mon();

    // reset and idle
    reset = 1'b1;
    step(4'hF, 1'b0);
    check_vec("reset_outs", 32'(outv), 32'h0);
    check_vec("reset_cnt", 32'(dut.u_timeout_cnt.cnt), 32'd0);
    check_vec("reset_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 1'b0);
      check_vec("idle_outs", 32'(outv), 32'h0);
    end
    check_vec("idle_state", 32'(dut.state), 32'(SHOW_TIME));
    step(4'hC, 1'b0);
    check_vec("code_c_ignored", 32'(dut.state), 32'(SHOW_TIME));

    // entry 1,2,3,0 then ALARM
    clr_mon();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        step(digs_a[i], 1'b0);
        if (i == 0 && j == 0) check_vec("first_shift_latency", 32'(outv), 32'b10100);
        if (i == 0 && j == 1) check_vec("held_no_reshift", 32'(outv), 32'b10000);
      end
      step(4'hF, 1'b0);
    end
    step(KEY_ALARM, 1'b0);
    check_vec("load_a_strobe", 32'(outv), 32'b10010);
    step(4'hF, 1'b0);
    check_vec("after_load_a", 32'(outv), 32'h0);
    check_vec("alarm_entry_shifts", 32'(n_shift), 32'd4);
    check_vec("alarm_entry_load_a", 32'(n_la), 32'd1);
    check_vec("alarm_entry_load_c", 32'(n_lc), 32'd0);
    check_vec("alarm_entry_snt_cycles", 32'(n_snt), 32'd17);

    // entry 0,7,4,5 then TIME
    clr_mon();
    for (int i = 0; i < 4; i++) begin
      step(digs_c[i], 1'b0);
      step(digs_c[i], 1'b0);
      step(4'hF, 1'b0);
    end
    step(KEY_TIME, 1'b0);
    check_vec("load_c_strobe", 32'(outv), 32'b10001);
    step(4'hF, 1'b0);
    check_vec("after_load_c", 32'(outv), 32'h0);
    check_vec("time_entry_shifts", 32'(n_shift), 32'd4);
    check_vec("time_entry_load_c", 32'(n_lc), 32'd1);
    check_vec("time_entry_load_a", 32'(n_la), 32'd0);
    check_vec("time_entry_snt_cycles", 32'(n_snt), 32'd13);

    // alarm display held 20 cycles
    clr_mon();
    for (int i = 0; i < 20; i++) begin
      step(KEY_ALARM, 1'b0);
      if (i == 0) check_vec("show_a_lag", 32'(outv), 32'b01000);
    end
    step(4'hF, 1'b0);
    check_vec("show_a_release", 32'(outv), 32'h0);
    check_vec("show_a_cycles", 32'(n_sa), 32'd20);

    // timeout after 10 pulses
    clr_mon();
    step(4'd9, 1'b0);
    step(4'd9, 1'b0);
    step(4'hE, 1'b0);
    check_vec("code_e_as_none", 32'(dut.state), 32'(KEY_ENTRY));
    for (int i = 0; i < 10; i++) begin
      step(4'hF, 1'b1);
      if (i == 8) check_vec("no_timeout_at_9", 32'(timeout), 32'd0);
    end
    check_vec("timeout_at_10", 32'(timeout), 32'd1);
    check_vec("timeout_outs", 32'(outv), 32'b10000);
    step(4'hF, 1'b1);
    check_vec("timeout_exit_state", 32'(dut.state), 32'(SHOW_TIME));
    check_vec("timeout_exit_outs", 32'(outv), 32'h0);
    check_vec("timeout_saturate", 32'(dut.u_timeout_cnt.cnt), 32'd10);
    step(4'hF, 1'b0);
    check_vec("timeout_cleared", 32'(timeout), 32'd0);
    check_vec("timeout_no_loads", 32'(n_la + n_lc), 32'd0);
    check_vec("timeout_shifts", 32'(n_shift), 32'd1);

    // digit on the 10th pulse wins over timeout
    step(4'd9, 1'b0);
    step(4'hF, 1'b0);
    step(4'hF, 1'b0);
    for (int i = 0; i < 9; i++) step(4'hF, 1'b1);
    step(4'd5, 1'b1);
    check_vec("digit_beats_timeout", 32'(outv), 32'b10100);
    check_vec("digit_beats_state", 32'(dut.state), 32'(KEY_STORED));
    step(4'hF, 1'b0);
    check_vec("after_race_outs", 32'(outv), 32'b10000);
    check_vec("after_race_cnt", 32'(dut.u_timeout_cnt.cnt), 32'd0);

    // reset mid-entry
    reset = 1'b1;
    step(4'hF, 1'b0);
    reset = 1'b0;
    step(4'd3, 1'b0);
    step(4'd3, 1'b0);
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    check_vec("pre_reset_cnt", 32'(dut.u_timeout_cnt.cnt), 32'd2);
    reset = 1'b1;
    step(KEY_ALARM, 1'b0);
    check_vec("midentry_reset_outs", 32'(outv), 32'h0);
    check_vec("midentry_reset_cnt", 32'(dut.u_timeout_cnt.cnt), 32'd0);
    reset = 1'b0;
    clr_mon();
    step(KEY_ALARM, 1'b0);
    check_vec("post_reset_show_a", 32'(outv), 32'b01000);
    step(4'hF, 1'b0);
    check_vec("post_reset_no_load_a", 32'(n_la), 32'd0);

    // reset while in a load state
    step(4'd2, 1'b0);
    step(4'd2, 1'b0);
    step(4'hF, 1'b0);
    step(KEY_ALARM, 1'b0);
    check_vec("pre_reset_load_a", 32'(outv), 32'b10010);
    reset = 1'b1;
    step(KEY_TIME, 1'b0);
    check_vec("load_reset_outs", 32'(outv), 32'h0);
    check_vec("load_reset_state", 32'(dut.state), 32'(SHOW_TIME));
    reset = 1'b0;
    step(4'hF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
